// File: rtl/play_session_pkg.sv
// play_session_pkg: shared state, judge and speed encodings for the play session
package play_session_pkg;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_DONE} state_t;
    typedef enum logic [1:0] {J_NONE = 2'b00, J_PERFECT = 2'b01, J_GOOD = 2'b10, J_MISS = 2'b11} judge_t;
    localparam logic [1:0] SPD_HALF = 2'b10;
    localparam logic [1:0] SPD_DOUBLE = 2'b11;
    localparam int REST = 0;
endpackage

// File: rtl/play_session_if.sv
// play_session_if: song ROM read port and player hit strobe
interface play_session_if #(
    parameter int NOTE_W = 5,
    parameter int LEN_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_note;
    logic [LEN_W-1:0] rom_len;
    logic hit_valid;
    logic [NOTE_W-1:0] hit_note;
    modport master (output rom_addr, input rom_note, rom_len, hit_valid, hit_note);
    modport slave (input rom_addr, output rom_note, rom_len, hit_valid, hit_note);
endinterface

// File: rtl/play_session_judge.sv
// play_judge: grades one hit against the goal note and returns saturated score/combo
module play_judge import play_session_pkg::*; #(
    parameter int NOTE_W = 5,
    parameter int EL_W = 9,
    parameter int SCORE_W = 21,
    parameter int COMBO_W = 12,
    parameter int WINDOW = 4,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS = 1
) (
    input  logic [NOTE_W-1:0] goal_note,
    input  logic [NOTE_W-1:0] hit_note,
    input  logic [EL_W-1:0] elapsed,
    input  logic judged,
    input  logic [SCORE_W-1:0] score,
    input  logic [COMBO_W-1:0] combo,
    output judge_t code,
    output logic [SCORE_W-1:0] score_n,
    output logic [COMBO_W-1:0] combo_n
);
    logic perfect;
    logic [SCORE_W:0] sum;
    always_comb begin
        perfect = 32'(elapsed) < WINDOW;
        code = judged || goal_note == NOTE_W'(REST) ? J_NONE :
               hit_note != goal_note ? J_MISS : perfect ? J_PERFECT : J_GOOD;
        sum = {1'b0, score} + (SCORE_W+1)'(perfect ? PERFECT_PTS : GOOD_PTS);
        score_n = code == J_PERFECT || code == J_GOOD ? (sum[SCORE_W] ? '1 : sum[SCORE_W-1:0]) : score;
        combo_n = code == J_MISS ? '0 : code == J_NONE || combo == '1 ? combo : combo + 1'b1;
    end
endmodule

// File: rtl/play_session.sv
// play_session: song sequencer, hit judge and per-user high-score table
module play_session import play_session_pkg::*; #(
    parameter int NOTE_W = 5,
    parameter int LEN_W = 8,
    parameter int ADDR_W = 8,
    parameter int USERS = 4,
    parameter int SCORE_W = 21,
    parameter int COMBO_W = 12,
    parameter int WINDOW = 4,
    parameter int PERFECT_PTS = 3,
    parameter int GOOD_PTS = 1,
    localparam int UID_W = USERS > 1 ? $clog2(USERS) : 1,
    localparam int EL_W = LEN_W + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic [1:0] speed,
    input  logic [UID_W-1:0] user_id,
    input  logic [ADDR_W-1:0] song_len,
    input  logic tick,
    play_session_if.master bus,
    output logic goal_valid,
    output logic [NOTE_W-1:0] goal_note,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] best_combo,
    output logic [1:0] judge,
    output logic done,
    output logic new_record,
    output logic [SCORE_W-1:0] hs_score
);
    state_t state, state_n;
    judge_t j_code, judge_n;
    logic [UID_W-1:0] user_q;
    logic [1:0] speed_q;
    logic [ADDR_W-1:0] len_q, addr_q;
    logic [EL_W-1:0] timer, elapsed, len_eff, load_val;
    logic judged, begin_s, play_go, tick_go, note_end, last, hit_judged, miss_end, commit;
    logic [SCORE_W-1:0] j_score, score_n;
    logic [COMBO_W-1:0] j_combo, combo_n, best_n;
    logic [COMBO_W+SCORE_W-1:0] tbl [USERS];

    assign bus.rom_addr = addr_q;

    play_judge #(
        .NOTE_W(NOTE_W), .EL_W(EL_W), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W),
        .WINDOW(WINDOW), .PERFECT_PTS(PERFECT_PTS), .GOOD_PTS(GOOD_PTS)
    ) u_judge (
        .goal_note(goal_note),
        .hit_note(bus.hit_note),
        .elapsed(elapsed),
        .judged(judged),
        .score(score),
        .combo(combo),
        .code(j_code),
        .score_n(j_score),
        .combo_n(j_combo)
    );

    // A hit landing on the note-ending tick is judged first and suppresses the end-of-note MISS.
    always_comb begin
        begin_s = start && (state == S_IDLE || state == S_DONE);
        play_go = state == S_PLAY && !pause;
        tick_go = play_go && tick;
        note_end = tick_go && timer == EL_W'(1);
        last = addr_q == len_q - 1'b1;
        hit_judged = play_go && bus.hit_valid && j_code != J_NONE;
        miss_end = note_end && !judged && !hit_judged && goal_note != NOTE_W'(REST);
        score_n = hit_judged ? j_score : score;
        combo_n = hit_judged ? j_combo : miss_end ? '0 : combo;
        best_n = combo_n > best_combo ? combo_n : best_combo;
        judge_n = hit_judged ? j_code : miss_end ? J_MISS : J_NONE;
        commit = note_end && last && score_n > tbl[user_q][SCORE_W-1:0];
        len_eff = bus.rom_len == '0 ? EL_W'(1) : EL_W'(bus.rom_len);
        load_val = speed_q == SPD_HALF ? len_eff << 1 :
                   speed_q == SPD_DOUBLE && len_eff > EL_W'(1) ? len_eff >> 1 : len_eff;
    end

    always_ff @(posedge clk) state <= rst ? S_IDLE : state_n;

    always_comb begin
        state_n = state;
        if (begin_s) state_n = song_len == '0 ? S_DONE : S_LOAD;
        else if (state == S_LOAD) state_n = S_PLAY;
        else if (note_end) state_n = last ? S_DONE : S_LOAD;
    end

    always_comb begin
        goal_valid = state == S_PLAY;
        done = state == S_DONE;
        hs_score = tbl[user_q][SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            user_q <= '0;
            speed_q <= '0;
            len_q <= '0;
            addr_q <= '0;
            goal_note <= '0;
            timer <= '0;
            elapsed <= '0;
            judged <= 1'b0;
            score <= '0;
            combo <= '0;
            best_combo <= '0;
            judge <= '0;
            new_record <= 1'b0;
            tbl <= '{default: '0};
        end else begin
            judge <= judge_n;
            if (begin_s) begin
                user_q <= user_id;
                speed_q <= speed;
                len_q <= song_len;
                addr_q <= '0;
                score <= '0;
                combo <= '0;
                best_combo <= '0;
                new_record <= 1'b0;
            end
            if (state == S_LOAD) begin
                goal_note <= bus.rom_note;
                timer <= load_val;
                elapsed <= '0;
                judged <= 1'b0;
            end
            if (state == S_PLAY) begin
                score <= score_n;
                combo <= combo_n;
                best_combo <= best_n;
                if (hit_judged) judged <= 1'b1;
                if (tick_go) begin
                    timer <= timer - 1'b1;
                    elapsed <= elapsed + 1'b1;
                end
                if (note_end && !last) addr_q <= addr_q + 1'b1;
            end
            if (commit) begin
                tbl[user_q] <= {best_n, score_n};
                new_record <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_play_session.sv
// tb_play_session: directed stimulus against a per-cycle reference model of the session rules
module tb_play_session;
    localparam int SW = 4, SMAX = 15, CMAX = 4095;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PLAY = 2, M_DONE = 3;
    logic clk = 0, rst = 1, start = 0, pause = 0, tick = 0;
    logic [1:0] speed = 0, user_id = 0, judge;
    logic [7:0] song_len = 0;
    logic goal_valid, done, new_record;
    logic [4:0] goal_note;
    logic [SW-1:0] score, hs_score;
    logic [11:0] combo, best_combo;
    logic [4:0] mem_note [256];
    logic [7:0] mem_len [256];
    int n_checks = 0, n_err = 0;
    bit chk_en = 0;
    int m_st, m_user, m_speed, m_len, m_idx, m_goal, m_left, m_el, m_judged;
    int m_score, m_combo, m_best, m_judge, m_rec;
    int m_hs [4];

    play_session_if #(.NOTE_W(5), .LEN_W(8), .ADDR_W(8)) bus ();
    assign bus.rom_note = mem_note[bus.rom_addr];
    assign bus.rom_len = mem_len[bus.rom_addr];

    play_session #(.SCORE_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .speed(speed),
        .user_id(user_id), .song_len(song_len), .tick(tick), .bus(bus),
        .goal_valid(goal_valid), .goal_note(goal_note), .score(score), .combo(combo),
        .best_combo(best_combo), .judge(judge), .done(done), .new_record(new_record),
        .hs_score(hs_score)
    );

    always #5 clk = ~clk;

    function automatic int mn(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int dur(input int len, input int spd);
        int l;
        l = len == 0 ? 1 : len;
        return spd == 2 ? 2 * l : spd == 3 ? (l / 2 > 0 ? l / 2 : 1) : l;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mstep();
        m_judge = 0;
        if (rst) begin
            {m_st, m_user, m_speed, m_len, m_idx, m_goal, m_left, m_el, m_judged} = '0;
            {m_score, m_combo, m_best, m_rec} = '0;
            foreach (m_hs[i]) m_hs[i] = 0;
        end else if (start && (m_st == M_IDLE || m_st == M_DONE)) begin
            m_user = int'(user_id);
            m_speed = int'(speed);
            m_len = int'(song_len);
            {m_idx, m_score, m_combo, m_best, m_rec} = '0;
            m_st = m_len == 0 ? M_DONE : M_LOAD;
        end else if (m_st == M_LOAD) begin
            m_goal = int'(mem_note[m_idx]);
            m_left = dur(int'(mem_len[m_idx]), m_speed);
            m_el = 0;
            m_judged = 0;
            m_st = M_PLAY;
        end else if (m_st == M_PLAY && !pause) begin
            if (bus.hit_valid && m_judged == 0 && m_goal != 0) begin
                m_judged = 1;
                if (int'(bus.hit_note) != m_goal) begin
                    m_judge = 3;
                    m_combo = 0;
                end else begin
                    m_judge = m_el < 4 ? 1 : 2;
                    m_score = mn(m_score + (m_el < 4 ? 3 : 1), SMAX);
                    m_combo = mn(m_combo + 1, CMAX);
                end
            end
            if (tick) begin
                m_el += 1;
                m_left -= 1;
                if (m_left == 0) begin
                    if (m_judged == 0 && m_goal != 0) begin
                        m_judge = 3;
                        m_combo = 0;
                    end
                    if (m_idx == m_len - 1) begin
                        m_st = M_DONE;
                        if (m_score > m_hs[m_user]) begin
                            m_hs[m_user] = m_score;
                            m_rec = 1;
                        end
                    end else begin
                        m_idx += 1;
                        m_st = M_LOAD;
                    end
                end
            end
            m_best = m_combo > m_best ? m_combo : m_best;
        end
    endtask

    initial forever begin
        @(posedge clk);
        mstep();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("score", int'(score), m_score);
            chk("combo", int'(combo), m_combo);
            chk("best_combo", int'(best_combo), m_best);
            chk("judge", int'(judge), m_judge);
            chk("done", int'(done), int'(m_st == M_DONE));
            chk("goal_valid", int'(goal_valid), int'(m_st == M_PLAY));
            chk("new_record", int'(new_record), m_rec);
            chk("hs_score", int'(hs_score), m_hs[m_user]);
            if (m_st == M_PLAY) chk("goal_note", int'(goal_note), m_goal);
            if (m_st == M_LOAD || m_st == M_PLAY) chk("rom_addr", int'(bus.rom_addr), m_idx);
        end
    end

    task automatic pulse(input bit t, input bit h, input int note);
        @(negedge clk);
        tick = t;
        bus.hit_valid = h;
        bus.hit_note = 5'(note);
        @(negedge clk);
        tick = 0;
        bus.hit_valid = 0;
    endtask

    task automatic go(input int u, input int spd, input int len);
        @(negedge clk);
        start = 1;
        user_id = 2'(u);
        speed = 2'(spd);
        song_len = 8'(len);
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) pulse(1, 0, 0);
        chk("wait_done", int'(done), 1);
    endtask

    task automatic song(input int idx, input int note, input int len);
        mem_note[idx] = 5'(note);
        mem_len[idx] = 8'(len);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) song(i, 0, 0);
        bus.hit_valid = 0;
        bus.hit_note = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("reset_score", int'(score), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_hs", int'(hs_score), 0);
        // two PERFECT hits at normal speed
        song(0, 5, 4);
        song(1, 7, 4);
        go(0, 0, 2);
        pulse(0, 1, 5);
        chk("t1_judge", int'(judge), 1);
        chk("t1_score_a", int'(score), 3);
        repeat (6) pulse(1, 0, 0);
        pulse(0, 1, 7);
        repeat (2) pulse(1, 0, 0);
        chk("t1_done", int'(done), 1);
        chk("t1_score", int'(score), 6);
        chk("t1_combo", int'(combo), 2);
        chk("t1_record", int'(new_record), 1);
        chk("t1_hs", int'(hs_score), 6);
        // double time, miss on second note
        go(1, 3, 2);
        pulse(1, 0, 0);
        pulse(0, 1, 5);
        chk("t2_judge_p", int'(judge), 1);
        repeat (3) pulse(1, 0, 0);
        chk("t2_done", int'(done), 1);
        chk("t2_judge_m", int'(judge), 3);
        chk("t2_combo", int'(combo), 0);
        chk("t2_score", int'(score), 3);
        chk("t2_best", int'(best_combo), 1);
        chk("t2_hs", int'(hs_score), 3);
        // late hit is GOOD, second hit ignored
        song(0, 9, 8);
        go(2, 0, 1);
        repeat (5) pulse(1, 0, 0);
        pulse(0, 1, 9);
        chk("t3_good", int'(judge), 2);
        chk("t3_score", int'(score), 1);
        pulse(0, 1, 9);
        chk("t3_rehit", int'(judge), 0);
        repeat (2) pulse(1, 0, 0);
        chk("t3_not_done", int'(done), 0);
        pulse(1, 0, 0);
        chk("t3_done", int'(done), 1);
        // pause freezes timer and judging
        go(3, 0, 1);
        repeat (2) pulse(1, 0, 0);
        pause = 1;
        repeat (10) pulse(1, 0, 0);
        pulse(0, 1, 9);
        chk("t4_paused_judge", int'(judge), 0);
        chk("t4_paused_valid", int'(goal_valid), 1);
        pause = 0;
        pulse(0, 1, 9);
        chk("t4_perfect", int'(judge), 1);
        repeat (5) pulse(1, 0, 0);
        chk("t4_not_done", int'(done), 0);
        pulse(1, 0, 0);
        chk("t4_done", int'(done), 1);
        chk("t4_hs", int'(hs_score), 3);
        // score saturation with hits on the note-ending tick
        for (int i = 0; i < 6; i++) song(i, 5, 1);
        go(0, 0, 6);
        repeat (6) pulse(1, 1, 5);
        chk("t5_done", int'(done), 1);
        chk("t5_score", int'(score), 15);
        chk("t5_combo", int'(combo), 6);
        chk("t5_judge", int'(judge), 1);
        chk("t5_hs", int'(hs_score), 15);
        go(0, 0, 1);
        pulse(1, 1, 5);
        chk("t5_low_score", int'(score), 3);
        chk("t5_no_record", int'(new_record), 0);
        chk("t5_hs_kept", int'(hs_score), 15);
        // rest note at half time, zero-length note
        song(0, 0, 2);
        song(1, 11, 0);
        go(3, 2, 2);
        pulse(0, 1, 4);
        chk("t6_rest_hit", int'(judge), 0);
        wait_done(20);
        chk("t6_miss", int'(judge), 3);
        chk("t6_no_record", int'(new_record), 0);
        // reset mid-play clears everything
        song(0, 5, 4);
        song(1, 7, 4);
        go(1, 0, 2);
        pulse(0, 1, 5);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("t7_score", int'(score), 0);
        chk("t7_combo", int'(combo), 0);
        chk("t7_valid", int'(goal_valid), 0);
        chk("t7_addr", int'(bus.rom_addr), 0);
        chk("t7_goal", int'(goal_note), 0);
        rst = 0;
        for (int u = 0; u < 4; u++) begin
            go(u, 0, 0);
            chk("t7_empty_done", int'(done), 1);
            chk("t7_hs_clear", int'(hs_score), 0);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
